// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 8x oversampling. The serial line is
//            synchronised, each frame is validated at mid-bit sample points,
//            and received bytes are handed over through a one-entry
//            valid/ready buffer. Framing errors and overruns are reported as
//            single-cycle pulses.
// Ports    : clk_i        - system clock
//            rst_i        - asynchronous active-high reset
//            rx_i         - serial line (asynchronous, idles high)
//            rx_data_o    - received byte
//            rx_valid_o   - rx_data_o holds an unconsumed byte
//            rx_ready_i   - consumer accepts byte when valid && ready
//            frame_err_o  - pulse: frame ended with a low stop bit
//            overrun_o    - pulse: completed byte dropped, buffer full
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned CLK_RATE  = 100_000_000,
  parameter int unsigned BAUD_RATE = 3_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // Prescaler period in clocks for one oversample tick (8 ticks per bit).
  localparam int unsigned DIV = CLK_RATE / (8 * BAUD_RATE);
  localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: DIV = CLK_RATE/(8*BAUD_RATE) must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    samp_q,  samp_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;
  logic          ovr_q,   ovr_d;

  logic          rxs;
  logic          tick;
  logic          commit;
  logic          handshake;

  assign rxs = sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      presc_q <= '0;
      samp_q  <= 3'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      presc_q <= presc_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    commit    = 1'b0;
    handshake = valid_q && rx_ready_i;
    tick      = (presc_q == PRESC_MAX);

    // Prescaler and sample counter free-run outside IDLE; both rest at 0 in
    // IDLE so START entry always begins a fresh bit period.
    if (state_q == ST_IDLE) begin
      presc_d = '0;
      samp_d  = 3'd0;
    end else if (tick) begin
      presc_d = '0;
      samp_d  = samp_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        // Mid-start-bit check; a high line here means the low was a glitch.
        if (tick && samp_q == 3'd3) begin
          if (!rxs) begin
            samp_d  = 3'd0;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        // samp wraps 7->0 here, so each sample lands 8 ticks after the last.
        if (tick && samp_q == 3'd7) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (tick && samp_q == 3'd7) begin
          state_d = ST_IDLE;
          if (rxs) begin
            commit = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // One-entry output buffer. A handshake in the commit cycle frees the
    // slot, so the new byte replaces the consumed one without an overrun.
    if (commit) begin
      if (!valid_q || handshake) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx at DIV=10 (80 clocks
//            per bit). Drives frames on rx_i, monitors pulses and handshakes,
//            and compares against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CYC = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_RATE (8_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (rx_valid && ready) hs_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    cycles(BIT_CYC);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  int f0, o0;

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    cycles(3);
    chk("reset_data",  32'(rx_data),   32'h00);
    chk("reset_valid", 32'(rx_valid),  32'h0);
    chk("reset_ferr",  32'(frame_err), 32'h0);
    chk("reset_ovr",   32'(overrun),   32'h0);
    rst = 1'b0;
    cycles(5);

    // Single byte with latency check
    f0 = ferr_cnt; o0 = ovr_cnt; rise_cyc = -1;
    send_byte(8'hA5, 1'b1);
    chk("single_latency", 32'(rise_cyc - start_cyc), 32'd763);
    chk("single_valid", 32'(rx_valid), 32'h1);
    chk("single_data",  32'(rx_data),  32'hA5);
    chk("single_ferr",  32'(ferr_cnt - f0), 32'd0);
    chk("single_ovr",   32'(ovr_cnt - o0),  32'd0);
    ready = 1'b1;
    cycles(2);
    chk("single_consumed", 32'(rx_valid), 32'h0);

    // Back-to-back bytes with ready held high
    hs_q.delete();
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    cycles(20);
    chk("b2b_count", 32'(hs_q.size()), 32'd3);
    chk("b2b_d0", 32'(hs_q[0]), 32'h00);
    chk("b2b_d1", 32'(hs_q[1]), 32'hFF);
    chk("b2b_d2", 32'(hs_q[2]), 32'h3C);
    chk("b2b_valid", 32'(rx_valid), 32'h0);
    chk("b2b_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
    ready = 1'b0;

    // Framing error, then a good byte
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h55, 1'b0);
    cycles(160);
    chk("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_valid", 32'(rx_valid), 32'h0);
    send_byte(8'h12, 1'b1);
    cycles(20);
    chk("ferr_next_valid", 32'(rx_valid), 32'h1);
    chk("ferr_next_data",  32'(rx_data),  32'h12);
    chk("ferr_next_count", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_ovr",        32'(ovr_cnt - o0), 32'd0);
    ready = 1'b1;
    cycles(2);
    chk("ferr_consumed", 32'(rx_valid), 32'h0);
    ready = 1'b0;

    // Overrun
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cycles(20);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_data",  32'(rx_data),  32'h11);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_ferr",  32'(ferr_cnt - f0), 32'd0);
    ready = 1'b1;
    cycles(2);
    chk("ovr_cleared", 32'(rx_valid), 32'h0);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    ready = 1'b0;

    // Glitch while idle
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(100);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_data",  32'(rx_data),  32'h11);
    chk("glitch_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

    // Reset during data bit 3 of 8'hC3
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    cycles(40);
    rst = 1'b1;
    cycles(2);
    chk("rst_mid_data",  32'(rx_data),   32'h00);
    chk("rst_mid_valid", 32'(rx_valid),  32'h0);
    chk("rst_mid_ferr",  32'(frame_err), 32'h0);
    chk("rst_mid_ovr",   32'(overrun),   32'h0);
    rx = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(100);
    chk("rst_post_valid", 32'(rx_valid), 32'h0);
    send_byte(8'h7E, 1'b1);
    cycles(20);
    chk("rst_next_valid", 32'(rx_valid), 32'h1);
    chk("rst_next_data",  32'(rx_data),  32'h7E);
    chk("rst_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
    ready = 1'b1;
    cycles(2);
    ready = 1'b0;

    // Line held low: one frame error per 10-bit period
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    cycles(1540);
    rx = 1'b1;
    cycles(200);
    chk("break_ferr",  32'(ferr_cnt - f0), 32'd2);
    chk("break_valid", 32'(rx_valid), 32'h0);
    chk("break_ovr",   32'(ovr_cnt - o0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
